// File: rtl/pwm_duty_capture_if.sv
// Bus bundle for pwm_duty_capture: measurement control in, duty/period results out.
// Min/max tracking signals exist only when PWM_CAPTURE_MINMAX_EN is defined.
interface pwm_duty_capture_if #(
  parameter int CNT_W = 7
);
  logic             Enable;
  logic             Pulse_In;
  logic [CNT_W-1:0] Duty_Count;
  logic [CNT_W-1:0] Period_Count;
  logic             Valid;
  logic             Stuck_Low;
  logic             Stuck_High;
`ifdef PWM_CAPTURE_MINMAX_EN
  logic             Minmax_Clr;
  logic [CNT_W-1:0] Duty_Min;
  logic [CNT_W-1:0] Duty_Max;

  modport master (
    output Enable, Pulse_In, Minmax_Clr,
    input  Duty_Count, Period_Count, Valid, Stuck_Low, Stuck_High, Duty_Min, Duty_Max
  );
  modport slave (
    input  Enable, Pulse_In, Minmax_Clr,
    output Duty_Count, Period_Count, Valid, Stuck_Low, Stuck_High, Duty_Min, Duty_Max
  );
`else
  modport master (
    output Enable, Pulse_In,
    input  Duty_Count, Period_Count, Valid, Stuck_Low, Stuck_High
  );
  modport slave (
    input  Enable, Pulse_In,
    output Duty_Count, Period_Count, Valid, Stuck_Low, Stuck_High
  );
`endif
endinterface

// File: rtl/pwm_duty_capture.sv
// Recovers high time and rise-to-rise period of an asynchronous PWM input, with stuck detection.
// Optional duty min/max tracking is enabled by defining PWM_CAPTURE_MINMAX_EN.
module pwm_duty_capture #(
  parameter int CNT_W       = 7,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 100
) (
  input logic             sysclk,
  input logic             reset,
  pwm_duty_capture_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_RISE,
    S_HIGH,
    S_LOW
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] TO_SAT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic [CNT_W-1:0]       hi_q, hi_d;
  logic [CNT_W-1:0]       lo_q, lo_d;
  logic [CNT_W-1:0]       idle_q, idle_d;
  logic [CNT_W-1:0]       duty_q, duty_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   stk_lo_q, stk_lo_d;
  logic                   stk_hi_q, stk_hi_d;

  logic             lvl, rise, fall, edge_any, timeout_hit;
  logic             period_evt, stuck_lo_evt, stuck_hi_evt;
  logic [CNT_W:0]   period_sum;
  logic [CNT_W-1:0] period_sat;

  assign lvl        = sync_q[SYNC_STAGES-1];
  assign rise       = lvl & ~prev_q;
  assign fall       = ~lvl & prev_q;
  assign edge_any   = rise | fall;
  // Fires only on the step into TIMEOUT; the saturated counter cannot re-trigger.
  assign timeout_hit = (idle_q == TO_LAST) && !edge_any;
  assign period_sum = {1'b0, hi_q} + {1'b0, lo_q};
  assign period_sat = period_sum[CNT_W] ? CNT_MAX : period_sum[CNT_W-1:0];

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], bus.Pulse_In};
    prev_d       = lvl;
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    duty_d       = duty_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    stk_lo_d     = stk_lo_q;
    stk_hi_d     = stk_hi_q;
    period_evt   = 1'b0;
    stuck_lo_evt = 1'b0;
    stuck_hi_evt = 1'b0;

    if (edge_any)              idle_d = '0;
    else if (idle_q != TO_SAT) idle_d = idle_q + CNT_ONE;
    else                       idle_d = idle_q;

    if (edge_any) begin
      stk_lo_d = 1'b0;
      stk_hi_d = 1'b0;
    end

    if (!bus.Enable) begin
      state_d  = S_IDLE;
      hi_d     = '0;
      lo_d     = '0;
      idle_d   = '0;
      stk_lo_d = 1'b0;
      stk_hi_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          hi_d    = '0;
          lo_d    = '0;
          idle_d  = '0;
          state_d = S_WAIT_RISE;
        end
        S_WAIT_RISE: begin
          if (rise) begin
            hi_d    = CNT_ONE;
            lo_d    = '0;
            state_d = S_HIGH;
          end else if (timeout_hit) begin
            stuck_hi_evt = lvl;
            stuck_lo_evt = ~lvl;
          end
        end
        S_HIGH: begin
          if (fall) begin
            lo_d    = CNT_ONE;
            state_d = S_LOW;
          end else if (timeout_hit) begin
            stuck_hi_evt = 1'b1;
          end else if (lvl && hi_q != CNT_MAX) begin
            hi_d = hi_q + CNT_ONE;
          end
        end
        S_LOW: begin
          if (rise) begin
            period_evt = 1'b1;
            hi_d       = CNT_ONE;
            lo_d       = '0;
            state_d    = S_HIGH;
          end else if (timeout_hit) begin
            stuck_lo_evt = 1'b1;
          end else if (!lvl && lo_q != CNT_MAX) begin
            lo_d = lo_q + CNT_ONE;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (period_evt) begin
        duty_d   = hi_q;
        period_d = period_sat;
        valid_d  = 1'b1;
      end
      if (stuck_lo_evt || stuck_hi_evt) begin
        duty_d   = stuck_hi_evt ? CNT_MAX : '0;
        period_d = stuck_hi_evt ? CNT_MAX : '0;
        stk_lo_d = stuck_lo_evt;
        stk_hi_d = stuck_hi_evt;
        valid_d  = 1'b1;
        state_d  = S_WAIT_RISE;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sync_q   <= '0;
      prev_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      idle_q   <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stk_lo_q <= 1'b0;
      stk_hi_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      idle_q   <= idle_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stk_lo_q <= stk_lo_d;
      stk_hi_q <= stk_hi_d;
    end
  end

  assign bus.Duty_Count   = duty_q;
  assign bus.Period_Count = period_q;
  assign bus.Valid        = valid_q;
  assign bus.Stuck_Low    = stk_lo_q;
  assign bus.Stuck_High   = stk_hi_q;

`ifdef PWM_CAPTURE_MINMAX_EN
  logic [CNT_W-1:0] min_q, min_d;
  logic [CNT_W-1:0] max_q, max_d;

  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (bus.Minmax_Clr) begin
      min_d = '1;
      max_d = '0;
    end else if (period_evt) begin
      if (hi_q < min_q) min_d = hi_q;
      if (hi_q > max_q) max_d = hi_q;
    end
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      min_q <= '1;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  assign bus.Duty_Min = min_q;
  assign bus.Duty_Max = max_q;
`endif

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Scoreboard bench for pwm_duty_capture: PWM frames in, expected reports queued per input rise.
module tb_pwm_duty_capture;

  localparam int CNT_W = 7;
  localparam int SYNC  = 2;
  localparam int TO    = 100;
  localparam int FRAME = 64;

  typedef struct {
    int     duty;
    int     period;
    bit     slo;
    bit     shi;
    longint cyc;
  } exp_t;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;
  int   cyc    = 0;
  int   n_checks = 0;
  int   n_err    = 0;
  exp_t sb[$];
  bit   armed     = 1'b0;
  int   prev_duty = 0;

  pwm_duty_capture_if #(.CNT_W(CNT_W)) bus ();

  pwm_duty_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TO)
  ) dut (
    .sysclk(sysclk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input int duty, input int period, input bit slo, input bit shi, input longint at);
    exp_t e;
    e.duty = duty; e.period = period; e.slo = slo; e.shi = shi; e.cyc = at;
    sb.push_back(e);
  endtask

  task automatic tick(input logic p);
    @(posedge sysclk);
    #1;
    bus.Pulse_In = p;
  endtask

  task automatic set_enable(input logic en);
    @(posedge sysclk);
    #1;
    bus.Enable = en;
    if (!en) armed = 1'b0;
  endtask

  // One 64-cycle frame; optionally toggles Enable at index chg_idx.
  task automatic frame(input int duty, input int chg_idx, input logic chg_en);
    bit ok;
    ok = bus.Enable;
    for (int i = 0; i < FRAME; i++) begin
      tick(i < duty);
      if (i == 0 && armed) push(prev_duty, FRAME, 1'b0, 1'b0, longint'(cyc + SYNC + 1));
      if (i == chg_idx) begin
        bus.Enable = chg_en;
        ok = 1'b0;
      end
    end
    armed     = ok;
    prev_duty = duty;
  endtask

  always @(negedge sysclk) begin
    if (!reset && bus.Valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_valid", longint'(bus.Valid), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq("duty", longint'(bus.Duty_Count), e.duty);
        check_eq("period", longint'(bus.Period_Count), e.period);
        check_eq("stuck_low_on_valid", longint'(bus.Stuck_Low), e.slo);
        check_eq("stuck_high_on_valid", longint'(bus.Stuck_High), e.shi);
        if (e.cyc >= 0) check_eq("valid_latency_cycle", longint'(cyc), e.cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
    $fatal(1);
  end

  initial begin
    bus.Enable   = 1'b0;
    bus.Pulse_In = 1'b0;
`ifdef PWM_CAPTURE_MINMAX_EN
    bus.Minmax_Clr = 1'b0;
`endif
    repeat (4) @(posedge sysclk);
    #1 reset = 1'b0;
    @(negedge sysclk);
    check_eq("rst_duty", longint'(bus.Duty_Count), 0);
    check_eq("rst_period", longint'(bus.Period_Count), 0);
    check_eq("rst_valid", longint'(bus.Valid), 0);
    check_eq("rst_stuck_low", longint'(bus.Stuck_Low), 0);
    check_eq("rst_stuck_high", longint'(bus.Stuck_High), 0);

    // Duty 10 steady state, then Enable dropped mid-HIGH and restored mid-LOW.
    set_enable(1'b1);
    repeat (6) frame(10, -1, 1'b1);
    frame(10, 5, 1'b0);
    repeat (2) frame(10, -1, 1'b0);
    @(negedge sysclk);
    check_eq("hold_duty", longint'(bus.Duty_Count), 10);
    check_eq("hold_period", longint'(bus.Period_Count), FRAME);
    frame(10, 30, 1'b1);
    repeat (3) frame(10, -1, 1'b1);

    // Boundary duties.
    repeat (4) frame(1, -1, 1'b1);
    repeat (4) frame(63, -1, 1'b1);
    @(negedge sysclk);
    check_eq("no_stuck_low", longint'(bus.Stuck_Low), 0);
    check_eq("no_stuck_high", longint'(bus.Stuck_High), 0);
    set_enable(1'b0);
    repeat (5) tick(1'b0);

    // Held low: single stuck-low report, cleared by the next real frame.
    push(0, 0, 1'b1, 1'b0, -1);
    set_enable(1'b1);
    repeat (250) tick(1'b0);
    @(negedge sysclk);
    check_eq("stuck_low_level", longint'(bus.Stuck_Low), 1);
    check_eq("stuck_low_not_high", longint'(bus.Stuck_High), 0);
    frame(20, -1, 1'b1);
    @(negedge sysclk);
    check_eq("stuck_low_cleared", longint'(bus.Stuck_Low), 0);
    repeat (2) frame(20, -1, 1'b1);
    set_enable(1'b0);
    repeat (5) tick(1'b0);

    // Held high: stuck-high with all-ones results; first fall clears it.
    push(127, 127, 1'b0, 1'b1, -1);
    set_enable(1'b1);
    repeat (250) tick(1'b1);
    @(negedge sysclk);
    check_eq("stuck_high_level", longint'(bus.Stuck_High), 1);
    check_eq("stuck_high_not_low", longint'(bus.Stuck_Low), 0);
    repeat (5) tick(1'b0);
    @(negedge sysclk);
    check_eq("stuck_high_cleared", longint'(bus.Stuck_High), 0);
    set_enable(1'b0);
    repeat (5) tick(1'b0);

`ifdef PWM_CAPTURE_MINMAX_EN
    set_enable(1'b1);
    for (int d = 1; d <= 63; d++) frame(d, -1, 1'b1);
    for (int d = 62; d >= 1; d--) frame(d, -1, 1'b1);
    set_enable(1'b0);
    repeat (5) tick(1'b0);
    @(negedge sysclk);
    check_eq("duty_min", longint'(bus.Duty_Min), 1);
    check_eq("duty_max", longint'(bus.Duty_Max), 63);
    @(posedge sysclk);
    #1 bus.Minmax_Clr = 1'b1;
    @(posedge sysclk);
    #1 bus.Minmax_Clr = 1'b0;
    @(negedge sysclk);
    check_eq("duty_min_clr", longint'(bus.Duty_Min), 127);
    check_eq("duty_max_clr", longint'(bus.Duty_Max), 0);
`endif

    repeat (10) tick(1'b0);
    check_eq("scoreboard_drained", longint'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
